// File: rtl/qeciphy_rx_mon_pkg.sv
// Shared types and constants for the RX link monitor.
package qeciphy_rx_mon_pkg;

   localparam logic [7:0]  K28_5  = 8'hBC;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned LANES  = 4;

   typedef enum logic [1:0] {
      WAIT_RST,
      HUNT,
      VERIFY,
      LOCKED
   } rx_mon_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [LANES-1:0]  charisk;
   } rx_payload_t;

endpackage

// File: rtl/qeciphy_rx_link_monitor_if.sv
// Decoded RX word in from the GT, aligned payload out to the link layer.
interface qeciphy_rx_link_monitor_if;
   import qeciphy_rx_mon_pkg::*;

   logic [DATA_W-1:0] rx_data;
   logic [LANES-1:0]  rx_charisk;
   logic [LANES-1:0]  rx_disperr;
   logic [LANES-1:0]  rx_notintable;
   logic [DATA_W-1:0] rx_data_out;
   logic [LANES-1:0]  rx_charisk_out;
   logic              rx_valid;

   modport master (
      output rx_data, rx_charisk, rx_disperr, rx_notintable,
      input  rx_data_out, rx_charisk_out, rx_valid
   );

   modport slave (
      input  rx_data, rx_charisk, rx_disperr, rx_notintable,
      output rx_data_out, rx_charisk_out, rx_valid
   );

endinterface

// File: rtl/qeciphy_rx_err_window.sv
// Windowed code-error counter; flags the word that brings the error count to threshold.
module qeciphy_rx_err_window #(
   parameter int unsigned ERR_WINDOW = 256,
   parameter int unsigned ERR_THRESH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic advance,
   input  logic code_err,
   output logic thresh_hit_c
);

   localparam int unsigned WIN_W = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
   localparam int unsigned ERR_W = $clog2(ERR_THRESH + 1);

   logic [WIN_W-1:0] win_cnt;
   logic [ERR_W-1:0] err_cnt;
   logic             wrap_c;

   assign wrap_c = (win_cnt == WIN_W'(ERR_WINDOW - 1));

   // An error on the wrap word opens the next window rather than closing the current one
   assign thresh_hit_c = advance && code_err && !wrap_c &&
                         (err_cnt == ERR_W'(ERR_THRESH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt <= '0;
         err_cnt <= '0;
      end else if (clear) begin
         win_cnt <= '0;
         err_cnt <= '0;
      end else if (advance) begin
         win_cnt <= win_cnt + WIN_W'(1);
         if (wrap_c) begin
            err_cnt <= code_err ? ERR_W'(1) : '0;
         end else if (code_err && (err_cnt != ERR_W'(ERR_THRESH))) begin
            err_cnt <= err_cnt + ERR_W'(1);
         end
      end
   end

endmodule

// File: rtl/qeciphy_rx_link_monitor.sv
// Comma lock FSM, comma-align gating and registered payload forwarding for the GTY RX path.
// Optional feature: define QECIPHY_RX_ERR_COUNTER_EN for the saturating err_count.
module qeciphy_rx_link_monitor
   import qeciphy_rx_mon_pkg::*;
#(
   parameter int unsigned LOCK_COMMAS = 8,
   parameter int unsigned ERR_WINDOW  = 256,
   parameter int unsigned ERR_THRESH  = 4,
   parameter logic [7:0]  COMMA_CHAR  = K28_5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       rx_reset_done,
   input  logic                       rx_byteisaligned,
   qeciphy_rx_link_monitor_if.slave   bus,
   output logic                       comma_align_en,
   output logic                       rx_locked,
   output logic                       lock_lost,
   output logic [15:0]                err_count
);

   localparam int unsigned GOOD_W = $clog2(LOCK_COMMAS + 1);

   rx_mon_state_t     state, state_next;
   logic [GOOD_W-1:0] good_cnt, good_next;
   rx_payload_t       payload;
   logic              code_err_c, comma0_c, mis_comma_c, thresh_hit_c;
   logic              lock_lost_next, valid_next;

   assign code_err_c = |(bus.rx_disperr | bus.rx_notintable);
   assign comma0_c   = (bus.rx_charisk == 4'b0001) && (bus.rx_data[7:0] == COMMA_CHAR) &&
                       !code_err_c;

   always_comb begin
      mis_comma_c = 1'b0;
      for (int i = 1; i < LANES; i++) begin
         if (bus.rx_charisk[i] && (bus.rx_data[8*i +: 8] == COMMA_CHAR)) mis_comma_c = 1'b1;
      end
   end

   qeciphy_rx_err_window #(
      .ERR_WINDOW (ERR_WINDOW),
      .ERR_THRESH (ERR_THRESH)
   ) u_err_window (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (state != LOCKED),
      .advance      (state == LOCKED),
      .code_err     (code_err_c),
      .thresh_hit_c (thresh_hit_c)
   );

   always_comb begin
      state_next = state;
      good_next  = good_cnt;
      unique case (state)
         WAIT_RST: if (rx_byteisaligned) state_next = HUNT;
         HUNT: begin
            if (comma0_c) begin
               state_next = VERIFY;
               good_next  = GOOD_W'(1);
            end
         end
         VERIFY: begin
            if (code_err_c || mis_comma_c) begin
               state_next = HUNT;
               good_next  = '0;
            end else if (comma0_c) begin
               good_next = good_cnt + GOOD_W'(1);
               if (good_next == GOOD_W'(LOCK_COMMAS)) state_next = LOCKED;
            end
         end
         LOCKED: begin
            if (thresh_hit_c || mis_comma_c) begin
               state_next = HUNT;
               good_next  = '0;
            end
         end
         default: state_next = WAIT_RST;
      endcase
      if (!rx_reset_done) begin
         state_next = WAIT_RST;
         good_next  = '0;
      end
      lock_lost_next = (state == LOCKED) && (state_next != LOCKED);
      // The word that drops lock is never marked valid, so rx_valid implies rx_locked
      valid_next     = (state == LOCKED) && (state_next == LOCKED) && !code_err_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= WAIT_RST;
         good_cnt       <= '0;
         comma_align_en <= 1'b1;
         rx_locked      <= 1'b0;
         lock_lost      <= 1'b0;
         bus.rx_valid   <= 1'b0;
         payload        <= '0;
      end else begin
         state          <= state_next;
         good_cnt       <= good_next;
         comma_align_en <= (state_next == WAIT_RST) || (state_next == HUNT);
         rx_locked      <= (state_next == LOCKED);
         lock_lost      <= lock_lost_next;
         bus.rx_valid   <= valid_next;
         payload.data   <= bus.rx_data;
         payload.charisk <= bus.rx_charisk;
      end
   end

   assign bus.rx_data_out    = payload.data;
   assign bus.rx_charisk_out = payload.charisk;

`ifdef QECIPHY_RX_ERR_COUNTER_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (code_err_c && (state != WAIT_RST) && (err_count != 16'hFFFF)) begin
         err_count <= err_count + 16'd1;
      end
   end
`else
   assign err_count = 16'h0;
`endif

endmodule

// File: tb/tb_qeciphy_rx_link_monitor.sv
// Randomised + directed bench for qeciphy_rx_link_monitor with a queue-based scoreboard.
module tb_qeciphy_rx_link_monitor;
   import qeciphy_rx_mon_pkg::*;

   localparam int LOCK_COMMAS = 8;
   localparam int ERR_WINDOW  = 256;
   localparam int ERR_THRESH  = 4;
   localparam int PH_RST = 0, PH_HUNT = 1, PH_VER = 2, PH_LOCK = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_reset_done = 1'b0;
   logic        rx_byteisaligned = 1'b0;
   logic        comma_align_en, rx_locked, lock_lost;
   logic [15:0] err_count;

   qeciphy_rx_link_monitor_if bus();

   qeciphy_rx_link_monitor #(
      .LOCK_COMMAS (LOCK_COMMAS),
      .ERR_WINDOW  (ERR_WINDOW),
      .ERR_THRESH  (ERR_THRESH),
      .COMMA_CHAR  (8'hBC)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .rx_reset_done    (rx_reset_done),
      .rx_byteisaligned (rx_byteisaligned),
      .bus              (bus),
      .comma_align_en   (comma_align_en),
      .rx_locked        (rx_locked),
      .lock_lost        (lock_lost),
      .err_count        (err_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        align, locked, lost, valid;
      logic [15:0] ec;
      logic [31:0] data;
      logic [3:0]  k;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // reference model: phase, clean-comma run, lock-relative word index and window error tally
   int m_ph = PH_RST;
   int m_good = 0, m_idx = 0, m_win = 0, m_errs = 0, m_ec = 0;

   task automatic step(input logic rd, input logic al, input logic [31:0] d,
                       input logic [3:0] k, input logic [3:0] de, input logic [3:0] nit);
      exp_t e;
      logic ce, c0, mis;
      int   nph, w;
      @(negedge clk);
      rx_reset_done     = rd;
      rx_byteisaligned  = al;
      bus.rx_data       = d;
      bus.rx_charisk    = k;
      bus.rx_disperr    = de;
      bus.rx_notintable = nit;
      ce  = |(de | nit);
      c0  = (k == 4'b0001) && (d[7:0] == 8'hBC) && !ce;
      mis = 1'b0;
      for (int i = 1; i < 4; i++) if (k[i] && d[8*i +: 8] == 8'hBC) mis = 1'b1;
      nph = m_ph;
      if (!rd) begin
         nph = PH_RST;
         m_good = 0;
      end else begin
         case (m_ph)
            PH_RST:  if (al) nph = PH_HUNT;
            PH_HUNT: if (c0) begin nph = PH_VER; m_good = 1; end
            PH_VER: begin
               if (ce || mis) begin
                  nph = PH_HUNT;
                  m_good = 0;
               end else if (c0) begin
                  m_good++;
                  if (m_good == LOCK_COMMAS) nph = PH_LOCK;
               end
            end
            default: begin
               // word k of a lock belongs to window (k+1)/ERR_WINDOW
               w = (m_idx + 1) / ERR_WINDOW;
               if (w != m_win) begin m_win = w; m_errs = 0; end
               if (ce) m_errs++;
               m_idx++;
               if (m_errs >= ERR_THRESH || mis) nph = PH_HUNT;
            end
         endcase
      end
      if (nph == PH_LOCK && m_ph != PH_LOCK) begin
         m_idx = 0; m_win = 0; m_errs = 0;
      end
`ifdef QECIPHY_RX_ERR_COUNTER_EN
      if (m_ph != PH_RST && ce && m_ec < 65535) m_ec++;
`endif
      e.align  = (nph == PH_RST) || (nph == PH_HUNT);
      e.locked = (nph == PH_LOCK);
      e.lost   = (m_ph == PH_LOCK) && (nph != PH_LOCK);
      e.valid  = (m_ph == PH_LOCK) && (nph == PH_LOCK) && !ce;
      e.ec     = 16'(m_ec);
      e.data   = d;
      e.k      = k;
      exp_q.push_back(e);
      m_ph = nph;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, $urandom, 4'b0000, 4'b0000, 4'b0000);
   endtask

   task automatic commas(input int n);
      logic [31:0] r;
      for (int i = 0; i < n; i++) begin
         r = $urandom;
         step(1'b1, 1'b1, {r[31:8], 8'hBC}, 4'b0001, 4'b0000, 4'b0000);
      end
   endtask

   task automatic err_word();
      step(1'b1, 1'b1, $urandom, 4'b0000, 4'(1 << $urandom_range(0, 3)), 4'b0000);
   endtask

   task automatic mis_word();
      logic [31:0] r;
      r = $urandom;
      step(1'b1, 1'b1, {r[31:24], 8'hBC, r[15:0]}, 4'b0100, 4'b0000, 4'b0000);
   endtask

   // monitor: one expected record per clocked word
   initial begin
      exp_t e;
      logic [19:0] act_s, exp_s;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act_s = {comma_align_en, rx_locked, lock_lost, bus.rx_valid, err_count};
            exp_s = {e.align, e.locked, e.lost, e.valid, e.ec};
            total++;
            if (act_s !== exp_s) begin
               bad++;
               $display("FAIL status t=%0t align/locked/lost/valid/ec got=%b/%b/%b/%b/%0d want=%b/%b/%b/%b/%0d",
                        $time, act_s[19], act_s[18], act_s[17], act_s[16], act_s[15:0],
                        exp_s[19], exp_s[18], exp_s[17], exp_s[16], exp_s[15:0]);
            end
            total++;
            if ({bus.rx_data_out, bus.rx_charisk_out} !== {e.data, e.k}) begin
               bad++;
               $display("FAIL payload t=%0t got=%h/%h want=%h/%h", $time,
                        bus.rx_data_out, bus.rx_charisk_out, e.data, e.k);
            end
         end
      end
   end

   initial begin
      int r;
      bus.rx_data = '0; bus.rx_charisk = '0; bus.rx_disperr = '0; bus.rx_notintable = '0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({comma_align_en, rx_locked, lock_lost, bus.rx_valid, err_count,
           bus.rx_data_out, bus.rx_charisk_out} !== {1'b1, 3'b000, 16'h0, 32'h0, 4'h0}) begin
         bad++;
         $display("FAIL reset got align=%b locked=%b lost=%b valid=%b ec=%0d data=%h want 1/0/0/0/0/0",
                  comma_align_en, rx_locked, lock_lost, bus.rx_valid, err_count, bus.rx_data_out);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // lock acquisition and payload forwarding
      idle(1);
      commas(8);
      step(1'b1, 1'b1, 32'h12345678, 4'b0000, 4'b0000, 4'b0000);
      idle(4);
      // three errors, window wrap, three more: lock held
      err_word(); idle(10); err_word(); idle(10); err_word();
      idle(260);
      err_word(); idle(5); err_word(); idle(5); err_word();
      idle(300);
      // four errors in one window: lock lost
      err_word(); err_word(); idle(3); err_word(); idle(2); err_word();
      idle(3);
      // verify interrupted by a misplaced comma
      commas(5); mis_word(); commas(7); idle(2); commas(1); idle(3);
      // misplaced comma while locked
      mis_word(); idle(2); commas(8); idle(3);
      // RX reset drop while locked
      step(1'b0, 1'b1, $urandom, 4'b0000, 4'b0000, 4'b0000);
      step(1'b0, 1'b1, $urandom, 4'b0000, 4'b0001, 4'b0000);
      step(1'b1, 1'b0, $urandom, 4'b0000, 4'b0000, 4'b0000);
      idle(1); commas(8); idle(3);

      for (int n = 0; n < 4000; n++) begin
         r = $urandom_range(0, 999);
         if (r < 2)        step(1'b0, 1'b1, $urandom, 4'b0000, 4'b0000, 4'b0000);
         else if (r < 4)   mis_word();
         else if (r < 10)  err_word();
         else if (r < 14)  step(1'b1, 1'b1, $urandom, 4'b0000, 4'b0000, 4'(1 << $urandom_range(0, 3)));
         else if (r < 20)  step(1'b1, 1'($urandom_range(0, 1)), $urandom, 4'b0000, 4'b0000, 4'b0000);
         else if (r < 270) commas(1);
         else              idle(1);
      end

      @(posedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d pending want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
